// File: rtl/fadd_pkg.sv
// Shared types and exponent saturation helper for the float adder exponent path.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package fadd_pkg;

  // Widest exponent / amount the helper handles; callers zero-extend into these.
  localparam int EXP_MAX_W = 16;
  localparam int AMT_MAX_W = 16;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [EXP_MAX_W-1:0] exp;
    logic                 ovf;
    logic                 unf;
  } sat_t;

  localparam logic [EXP_MAX_W+1:0] ONE_X = 1;

  // Adjust a biased exponent of width exp_w by +/-amt and saturate to inf / zero.
  // Only the low exp_w bits of the returned exponent are meaningful.
  function automatic sat_t exp_sat(input logic [EXP_MAX_W-1:0] exp,
                                   input op_e                  op,
                                   input logic [AMT_MAX_W-1:0] amt,
                                   input int unsigned          exp_w);
    logic signed [EXP_MAX_W+1:0] r;
    logic signed [EXP_MAX_W+1:0] amt_x;
    logic signed [EXP_MAX_W+1:0] top;
    sat_t                        o;
    r     = $signed({2'b00, exp});
    amt_x = $signed({2'b00, amt});
    top   = $signed((ONE_X << exp_w) - ONE_X);
    o.exp = exp;
    o.ovf = 1'b0;
    o.unf = 1'b0;
    if (op == OP_INC || op == OP_DEC) begin
      if (op == OP_INC) r = r + amt_x;
      else              r = r - amt_x;
      if (r >= top) begin
        o.ovf = 1'b1;
        o.exp = top[EXP_MAX_W-1:0];
      end else if (r[EXP_MAX_W+1] || (r == '0)) begin
        o.unf = 1'b1;
        o.exp = '0;
      end else begin
        o.exp = r[EXP_MAX_W-1:0];
      end
    end
    // Pass and reserved forward the operand untouched, including all-ones.
    return o;
  endfunction

endpackage

// File: rtl/exp_skid_buf.sv
// Generic 2-entry valid/ready buffer; output always driven from the main register.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: absorbs one extra beat in the skid slot; in_ready drops only when both slots are full.
module exp_skid_buf
  import fadd_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dat
);

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer, out_xfer;

  assign in_ready  = (state_q != S_TWO) && !res;
  assign out_valid = (state_q != S_EMPTY);
  assign out_dat   = main_q;

  // Next-state and data movement; main holds the oldest beat, skid the next one.
  always_comb begin
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d = S_ONE;
          main_d  = in_dat;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_dat;
        end else if (in_xfer) begin
          state_d = S_TWO;
          skid_d  = in_dat;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State and storage registers; reset discards both entries.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/exp_adjust_unit.sv
// Exponent +/-amt adjust with inf/zero saturation, registered through a 2-entry skid buffer.
// Latency: 1 cycle; optional sticky ovf/unf flags with EXP_ADJ_STICKY_EN defined.
// Backpressure: valid/ready; in_ready low when both buffer entries are occupied or in reset.
module exp_adjust_unit
  import fadd_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_ovf,
  output logic             out_unf
`ifdef EXP_ADJ_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_ovf,
  output logic             sticky_unf
`endif
);

  sat_t                     sat;
  logic [EXP_W+1:0]         in_dat;
  logic [EXP_W+1:0]         out_dat;
  logic [EXP_MAX_W-EXP_W:0] unused_sat_hi;

  // Saturating adjust on the incoming operand, packed as {exp, ovf, unf}.
  always_comb begin
    sat    = exp_sat(EXP_MAX_W'(in_exp), op_e'(in_op), AMT_MAX_W'(in_amt), unsigned'(EXP_W));
    in_dat = {sat.exp[EXP_W-1:0], sat.ovf, sat.unf};
  end

  assign unused_sat_hi = {sat.exp[EXP_MAX_W-1:EXP_W], 1'b0};

  exp_skid_buf #(
    .DATA_W(EXP_W + 2)
  ) u_buf (
    .clk      (clk),
    .res      (res),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dat   (in_dat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dat  (out_dat)
  );

  assign {out_exp, out_ovf, out_unf} = out_dat;

`ifdef EXP_ADJ_STICKY_EN
  logic sticky_ovf_q, sticky_ovf_d;
  logic sticky_unf_q, sticky_unf_d;
  logic out_xfer;

  // Sticky flags: set on an output transfer carrying the flag, which beats a same-cycle clear.
  always_comb begin
    out_xfer     = out_valid && out_ready;
    sticky_ovf_d = sticky_clr ? 1'b0 : sticky_ovf_q;
    sticky_unf_d = sticky_clr ? 1'b0 : sticky_unf_q;
    if (out_xfer && out_ovf) sticky_ovf_d = 1'b1;
    if (out_xfer && out_unf) sticky_unf_d = 1'b1;
  end

  // Sticky flag registers.
  always_ff @(posedge clk) begin
    if (res) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;
`endif

endmodule

// File: tb/tb_exp_adjust_unit.sv
// Directed bench for exp_adjust_unit: single/double exponent widths, saturation, skid buffering.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: exercised by holding out_ready low while pushing beats.
module tb_exp_adjust_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       res;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_exp, out_exp;
  logic [1:0] in_op;
  logic [4:0] in_amt;
  logic       out_ovf, out_unf;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [10:0] w_in_exp, w_out_exp;
  logic [1:0]  w_in_op;
  logic [4:0]  w_in_amt;
  logic        w_out_ovf, w_out_unf;

`ifdef EXP_ADJ_STICKY_EN
  logic sticky_clr, sticky_ovf, sticky_unf;
  logic w_sticky_clr, w_sticky_ovf, w_sticky_unf;
`endif

  exp_adjust_unit #(.EXP_W(8), .AMT_W(5)) dut (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_ovf(out_ovf), .out_unf(out_unf)
`ifdef EXP_ADJ_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
`endif
  );

  exp_adjust_unit #(.EXP_W(11), .AMT_W(5)) dut_w (
    .clk(clk), .res(res),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_exp(w_in_exp), .in_op(w_in_op), .in_amt(w_in_amt),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_exp(w_out_exp), .out_ovf(w_out_ovf), .out_unf(w_out_unf)
`ifdef EXP_ADJ_STICKY_EN
    , .sticky_clr(w_sticky_clr), .sticky_ovf(w_sticky_ovf), .sticky_unf(w_sticky_unf)
`endif
  );

  // Directed vectors for the 8-bit instance: operand, op, amount -> {exp, ovf, unf}.
  logic [7:0] t_exp [12] = '{8'h7F, 8'hFC, 8'h03, 8'hFE, 8'hFE, 8'h01,
                             8'h00, 8'hFF, 8'h10, 8'h05, 8'hF0, 8'h02};
  logic [1:0] t_op  [12] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2,
                             2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd2};
  logic [4:0] t_amt [12] = '{5'd3, 5'd5, 5'd3, 5'd1, 5'd0, 5'd0,
                             5'd0, 5'd7, 5'd5, 5'd31, 5'd31, 5'd1};
  logic [9:0] t_res [12] = '{{8'h82, 2'b00}, {8'hFF, 2'b10}, {8'h00, 2'b01},
                             {8'hFF, 2'b10}, {8'hFE, 2'b00}, {8'h01, 2'b00},
                             {8'h00, 2'b00}, {8'hFF, 2'b00}, {8'h10, 2'b00},
                             {8'h00, 2'b01}, {8'hFF, 2'b10}, {8'h01, 2'b00}};

  task automatic test_reset();
    res = 1'b1; in_valid = 1'b1; in_exp = 8'h55; in_op = 2'd1; in_amt = 5'd1; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_exp = '0; w_in_op = '0; w_in_amt = '0; w_out_ready = 1'b1;
`ifdef EXP_ADJ_STICKY_EN
    sticky_clr = 1'b0; w_sticky_clr = 1'b0;
`endif
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_exp, out_ovf, out_unf} !== 12'h000) begin
        failures++;
        $display("FAIL reset_hold: valid=%b rdy=%b exp=%h ovf=%b unf=%b, want all zero",
                 out_valid, in_ready, out_exp, out_ovf, out_unf);
      end
    end
    res = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_release: valid=%b rdy=%b, want valid=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_exp = 8'h7F; in_op = 2'd1; in_amt = 5'd3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_exp, out_ovf, out_unf} !== {1'b1, 8'h82, 2'b00}) begin
      failures++;
      $display("FAIL basic_inc: valid=%b exp=%h ovf=%b unf=%b, want 1 82 0 0",
               out_valid, out_exp, out_ovf, out_unf);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_exp = t_exp[0]; in_op = t_op[0]; in_amt = t_amt[0];
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_exp, out_ovf, out_unf} !== {2'b11, t_res[i-1]}) begin
        failures++;
        $display("FAIL b2b_row%0d: valid=%b rdy=%b exp=%h ovf=%b unf=%b, want 1 1 %h %b %b",
                 i - 1, out_valid, in_ready, out_exp, out_ovf, out_unf,
                 t_res[i-1][9:2], t_res[i-1][1], t_res[i-1][0]);
      end
      if (i < 12) begin
        in_exp = t_exp[i]; in_op = t_op[i]; in_amt = t_amt[i];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_exp = 8'h20; in_op = 2'd1; in_amt = 5'd1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_exp} !== {2'b11, 8'h21}) begin
      failures++;
      $display("FAIL stall_first: valid=%b rdy=%b exp=%h, want 1 1 21", out_valid, in_ready, out_exp);
    end
    in_exp = 8'h40; in_op = 2'd2; in_amt = 5'd2;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_full: rdy=%b, want 0", in_ready);
    end
    in_exp = 8'h60; in_op = 2'd0; in_amt = 5'd0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_exp, out_ovf, out_unf} !== {2'b10, 8'h21, 2'b00}) begin
        failures++;
        $display("FAIL stall_hold: valid=%b rdy=%b exp=%h, want 1 0 21", out_valid, in_ready, out_exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_exp} !== {2'b11, 8'h3E}) begin
      failures++;
      $display("FAIL stall_second: valid=%b rdy=%b exp=%h, want 1 1 3e", out_valid, in_ready, out_exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_exp} !== {1'b1, 8'h60}) begin
      failures++;
      $display("FAIL stall_third: valid=%b exp=%h, want 1 60", out_valid, out_exp);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_exp = 8'h11; in_op = 2'd1; in_amt = 5'd1;
    @(negedge clk);
    in_exp = 8'h22;
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_exp} !== 10'h000) begin
      failures++;
      $display("FAIL mid_reset: valid=%b rdy=%b exp=%h, want 0 0 00", out_valid, in_ready, out_exp);
    end
    res = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL mid_reset_discard: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

`ifdef EXP_ADJ_STICKY_EN
  task automatic test_sticky();
    out_ready = 1'b1;
    checks++;
    if ({sticky_ovf, sticky_unf} !== 2'b00) begin
      failures++;
      $display("FAIL sticky_init: ovf=%b unf=%b, want 0 0", sticky_ovf, sticky_unf);
    end
    in_valid = 1'b1; in_exp = 8'hFC; in_op = 2'd1; in_amt = 5'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({sticky_ovf, sticky_unf} !== 2'b10) begin
        failures++;
        $display("FAIL sticky_set: ovf=%b unf=%b, want 1 0", sticky_ovf, sticky_unf);
      end
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; sticky_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (sticky_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set_wins: ovf=%b, want 1", sticky_ovf);
    end
    @(negedge clk);
    sticky_clr = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear: ovf=%b, want 0", sticky_ovf);
    end
    in_valid = 1'b1; in_exp = 8'h03; in_op = 2'd2; in_amt = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({sticky_ovf, sticky_unf} !== 2'b01) begin
      failures++;
      $display("FAIL sticky_unf: ovf=%b unf=%b, want 0 1", sticky_ovf, sticky_unf);
    end
  endtask
`endif

  task automatic test_wide();
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_exp = 11'h7FE; w_in_op = 2'd1; w_in_amt = 5'd1;
    @(negedge clk);
    checks++;
    if ({w_out_valid, w_out_exp, w_out_ovf, w_out_unf} !== {1'b1, 11'h7FF, 2'b10}) begin
      failures++;
      $display("FAIL wide_ovf: valid=%b exp=%h ovf=%b unf=%b, want 1 7ff 1 0",
               w_out_valid, w_out_exp, w_out_ovf, w_out_unf);
    end
    w_in_exp = 11'h7FF; w_in_op = 2'd0; w_in_amt = 5'd0;
    @(negedge clk);
    checks++;
    if ({w_out_valid, w_out_exp, w_out_ovf, w_out_unf} !== {1'b1, 11'h7FF, 2'b00}) begin
      failures++;
      $display("FAIL wide_pass_inf: valid=%b exp=%h ovf=%b unf=%b, want 1 7ff 0 0",
               w_out_valid, w_out_exp, w_out_ovf, w_out_unf);
    end
    w_in_exp = 11'h7FD; w_in_op = 2'd1; w_in_amt = 5'd1;
    @(negedge clk);
    checks++;
    if ({w_out_valid, w_out_exp, w_out_ovf, w_out_unf} !== {1'b1, 11'h7FE, 2'b00}) begin
      failures++;
      $display("FAIL wide_inc: valid=%b exp=%h ovf=%b unf=%b, want 1 7fe 0 0",
               w_out_valid, w_out_exp, w_out_ovf, w_out_unf);
    end
    w_in_exp = 11'h002; w_in_op = 2'd2; w_in_amt = 5'd3;
    @(negedge clk);
    w_in_valid = 1'b0;
    checks++;
    if ({w_out_valid, w_out_exp, w_out_ovf, w_out_unf} !== {1'b1, 11'h000, 2'b01}) begin
      failures++;
      $display("FAIL wide_unf: valid=%b exp=%h ovf=%b unf=%b, want 1 000 0 1",
               w_out_valid, w_out_exp, w_out_ovf, w_out_unf);
    end
    @(negedge clk);
    checks++;
    if (w_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wide_drain: valid=%b, want 0", w_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef EXP_ADJ_STICKY_EN
    test_sticky();
`endif
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
